div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage of the MIPS pipeline. It executes DIV/DIVU and produces the `div_stall` request that the hazard unit uses to freeze the front of the pipeline. While the division is in flight it holds EX. It releases the stall for exactly the cycle in which quotient/remainder are valid for HI/LO writeback. It aborts cleanly when an exception flush hits the EX stage.

---
 rtl/div_pkg.sv | 11 +
 rtl/div_if.sv | 25 ++
 rtl/div_step.sv | 19 +
 rtl/div_unit.sv | 115 +++++++++++
 tb/tb_div_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;
    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_W) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;
endpackage

// File: rtl/div_if.sv
// EX-stage divider handshake: issue/operands from the pipeline, stall and HI/LO result back.
interface div_if #(
    parameter int WIDTH = div_pkg::DIV_W
);
    logic             start;
    logic             sign_en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hold;
    logic             div_stall;
    logic             result_valid;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    modport master (
        output start, sign_en, a, b, cancel, hold,
        input  div_stall, result_valid, lo, hi
    );

    modport slave (
        input  start, sign_en, a, b, cancel, hold,
        output div_stall, result_valid, lo, hi
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit, trial-subtract.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bitIn,
    output logic [WIDTH-1:0] remOut,
    output logic             qBit
);
    logic [WIDTH:0] shifted;

    assign shifted = {remIn, bitIn};
    assign qBit    = (shifted >= {1'b0, divisor});
    // Only the low WIDTH bits survive; the kept remainder is always below the divisor.
    assign remOut  = shifted[WIDTH-1:0] - (qBit ? divisor : '0);
endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for EX with pipeline stall request and flush abort.
// Optional early-out for b==0 or |a|<|b| when DIV_FAST_PATH_EN is defined.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input logic  clk,
    input logic  rst,
    div_if.slave bus
);
    localparam int CntW = $clog2(WIDTH) + 1;

    div_state_t       state, nextState;
    logic [CntW-1:0]  iterCnt;
    logic [WIDTH-1:0] remReg, quoReg, divisorReg, dividendRaw;
    logic [WIDTH-1:0] loReg, hiReg;
    logic             negQuo, negRem, divZero;
    logic [WIDTH-1:0] aMag, bMag, stepRem, quoFinal, loFinal, hiFinal;
    logic             stepQ, issue, lastStep, fastTake;

    assign aMag = (bus.sign_en && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign bMag = (bus.sign_en && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign issue    = (state == DIV_IDLE) && bus.start && !bus.cancel;
    assign lastStep = (state == DIV_BUSY) && (iterCnt == CntW'(WIDTH - 1));

`ifdef DIV_FAST_PATH_EN
    assign fastTake = issue && ((bus.b == '0) || (aMag < bMag));
`else
    assign fastTake = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) uStep (
        .remIn   (remReg),
        .divisor (divisorReg),
        .bitIn   (quoReg[WIDTH-1]),
        .remOut  (stepRem),
        .qBit    (stepQ)
    );

    // Dividend bits shift out of the top of quoReg as quotient bits shift in at the bottom.
    assign quoFinal = {quoReg[WIDTH-2:0], stepQ};
    assign loFinal  = divZero ? '1 : (negQuo ? -quoFinal : quoFinal);
    assign hiFinal  = divZero ? dividendRaw : (negRem ? -stepRem : stepRem);

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState     = state;
        bus.div_stall = 1'b0;
        unique case (state)
            DIV_IDLE: begin
                bus.div_stall = bus.start;
                if (bus.start) nextState = fastTake ? DIV_DONE : DIV_BUSY;
            end
            DIV_BUSY: begin
                bus.div_stall = 1'b1;
                if (lastStep) nextState = DIV_DONE;
            end
            DIV_DONE: begin
                if (!bus.hold) nextState = DIV_IDLE;
            end
            default: nextState = DIV_IDLE;
        endcase
        // A flush of EX wins over issue, iteration and parked results alike.
        if (bus.cancel) begin
            nextState     = DIV_IDLE;
            bus.div_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iterCnt     <= '0;
            remReg      <= '0;
            quoReg      <= '0;
            divisorReg  <= '0;
            dividendRaw <= '0;
            negQuo      <= 1'b0;
            negRem      <= 1'b0;
            divZero     <= 1'b0;
            loReg       <= '0;
            hiReg       <= '0;
        end else if (issue) begin
            iterCnt     <= '0;
            remReg      <= '0;
            quoReg      <= aMag;
            divisorReg  <= bMag;
            dividendRaw <= bus.a;
            negQuo      <= bus.sign_en & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            negRem      <= bus.sign_en & bus.a[WIDTH-1];
            divZero     <= (bus.b == '0);
            if (fastTake) begin
                loReg <= (bus.b == '0) ? '1 : '0;
                hiReg <= bus.a;
            end
        end else if ((state == DIV_BUSY) && !bus.cancel) begin
            remReg  <= stepRem;
            quoReg  <= quoFinal;
            iterCnt <= iterCnt + 1'b1;
            if (lastStep) begin
                loReg <= loFinal;
                hiReg <= hiFinal;
            end
        end
    end

    assign bus.result_valid = (state == DIV_DONE);
    assign bus.lo           = loReg;
    assign bus.hi           = hiReg;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed DIV/DIVU vectors, stall timing, cancel, hold and reset.
module tb_div_unit;
    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nCmp = 0;
    int   nErr = 0;
    exp_t expQ[$];
    exp_t monE;
    logic rvPrev = 1'b0;

    div_if #(.WIDTH(32)) dif ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every rising edge of result_valid consumes one expected result.
    always @(negedge clk) begin
        if (!rst && dif.result_valid && !rvPrev) begin
            if (expQ.size() == 0) begin
                nCmp++;
                nErr++;
                $display("FAIL unexpected_result: lo=0x%08h hi=0x%08h, no result expected", dif.lo, dif.hi);
            end else begin
                monE = expQ.pop_front();
                check({monE.nm, "_lo"}, dif.lo, monE.lo);
                check({monE.nm, "_hi"}, dif.hi, monE.hi);
            end
        end
        rvPrev = dif.result_valid;
    end

    task automatic doDiv(input string nm, input logic [31:0] av, input logic [31:0] bv,
                         input logic sg, input logic [31:0] eLo, input logic [31:0] eHi,
                         input bit fastOk, input int holdCyc);
        int   cyc;
        int   stallCnt;
        int   rvCnt;
        int   eLat;
        exp_t e;
        eLat = 33;
`ifdef DIV_FAST_PATH_EN
        if (fastOk) eLat = 1;
`else
        if (fastOk) eLat = 33;
`endif
        e.lo = eLo;
        e.hi = eHi;
        e.nm = nm;
        expQ.push_back(e);
        dif.start   = 1'b1;
        dif.a       = av;
        dif.b       = bv;
        dif.sign_en = sg;
        #1;
        cyc      = 0;
        stallCnt = 0;
        while (!dif.result_valid && cyc < 100) begin
            if (dif.div_stall) stallCnt++;
            @(negedge clk); #1;
            cyc++;
        end
        check({nm, "_latency"}, cyc, eLat);
        check({nm, "_stall_cycles"}, stallCnt, eLat);
        check({nm, "_stall_in_done"}, {31'b0, dif.div_stall}, 32'd0);
        rvCnt = 0;
        for (int h = 0; h < holdCyc; h++) begin
            dif.hold = 1'b1;
            if (dif.result_valid) rvCnt++;
            @(negedge clk); #1;
        end
        dif.hold  = 1'b0;
        dif.start = 1'b0;
        if (dif.result_valid) rvCnt++;
        check({nm, "_valid_cycles"}, rvCnt, holdCyc + 1);
        @(negedge clk); #1;
        check({nm, "_valid_after"}, {31'b0, dif.result_valid}, 32'd0);
        check({nm, "_idle_stall"}, {31'b0, dif.div_stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.start   = 1'b0;
        dif.sign_en = 1'b0;
        dif.a       = '0;
        dif.b       = '0;
        dif.cancel  = 1'b0;
        dif.hold    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_lo", dif.lo, 32'd0);
        check("reset_hi", dif.hi, 32'd0);
        check("reset_valid", {31'b0, dif.result_valid}, 32'd0);
        check("reset_stall", {31'b0, dif.div_stall}, 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        doDiv("divu_100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 0);
        doDiv("div_m7_2",    32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 0);
        doDiv("div_7_m2",    32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 0);
        doDiv("div_ovf",     32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 0);
        doDiv("divu_5_0",    32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          1'b1, 0);
        doDiv("div_m5_0",    32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 0);
        doDiv("divu_3_9",    32'd3,          32'd9,          1'b0, 32'd0,          32'd3,          1'b1, 0);
        doDiv("div_m3_7",    32'hFFFFFFFD,   32'd7,          1'b1, 32'd0,          32'hFFFFFFFD,   1'b1, 0);

        // Cancel at BUSY iteration 10: issue cycle T, iteration k at T+k+1.
        dif.start   = 1'b1;
        dif.a       = 32'd100;
        dif.b       = 32'd7;
        dif.sign_en = 1'b0;
        repeat (11) @(negedge clk);
        #1;
        dif.cancel = 1'b1;
        #1;
        check("cancel_stall_same_cycle", {31'b0, dif.div_stall}, 32'd0);
        @(negedge clk); #1;
        dif.cancel = 1'b0;
        dif.start  = 1'b0;
        #1;
        check("cancel_idle_stall", {31'b0, dif.div_stall}, 32'd0);
        check("cancel_no_valid", {31'b0, dif.result_valid}, 32'd0);
        @(negedge clk); #1;
        doDiv("divu_1000_10", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 0);

        doDiv("divu_hold", 32'hFFFFFFFF, 32'd16, 1'b0, 32'h0FFFFFFF, 32'd15, 1'b0, 3);

        // Reset in the middle of a division discards it.
        dif.start   = 1'b1;
        dif.a       = 32'd100;
        dif.b       = 32'd7;
        dif.sign_en = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        rst       = 1'b1;
        dif.start = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        check("midrst_lo", dif.lo, 32'd0);
        check("midrst_hi", dif.hi, 32'd0);
        check("midrst_valid", {31'b0, dif.result_valid}, 32'd0);
        check("midrst_stall", {31'b0, dif.div_stall}, 32'd0);
        repeat (40) @(negedge clk);
        #1;
        check("midrst_still_idle", {31'b0, dif.div_stall}, 32'd0);
        check("scoreboard_empty", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
